// File: rtl/dbus_mem_responder.sv
// Data-bus responder: serves ezpipe dbus loads/stores from an internal word RAM
// after a programmable number of wait states, one ready pulse per request.
module dbus_mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data_wr,
  input  logic [3:0]  dbus_wmask,
  input  logic        dbus_rd,
  input  logic        dbus_wr,
  output logic [31:0] dbus_data_rd,
  output logic        dbus_data_ready,
  output logic        dbus_error
);

  localparam int unsigned Depth    = 1 << ADDR_BITS;
  localparam logic [32:0] MemBytes = 33'(4) << ADDR_BITS;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES - 1);
  localparam bit          NoWait   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic        rd_q, wr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [Depth];

  logic                 req, capture, access;
  logic [31:0]          acc_addr, acc_wdata, offset;
  logic [3:0]           acc_wmask;
  logic                 acc_rd, acc_wr, acc_err;
  logic [ADDR_BITS-1:0] idx;

  assign req     = dbus_rd | dbus_wr;
  assign capture = (state_q == StIdle) && req;

  // With zero wait states the access happens on the capture edge, so the live
  // bus fields are used; otherwise the latched copy is used.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = dbus_addr;
      acc_wdata = dbus_data_wr;
      acc_wmask = dbus_wmask;
      acc_rd    = dbus_rd;
      acc_wr    = dbus_wr;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
    end
  end

  // Unsigned wrap makes addresses below BASE_ADDR land out of range too.
  assign offset  = acc_addr - BASE_ADDR;
  assign acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, offset} >= MemBytes) ||
                   (acc_rd && acc_wr);
  assign idx     = offset[ADDR_BITS+1:2];

  // Next-state logic: IDLE -> (WAIT countdown) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (NoWait) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        err_q <= acc_err;
        if (acc_err) begin
          rdata_q <= 32'd0;
        end else if (acc_rd) begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  // Request capture; held through WAIT so bus changes are ignored.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= dbus_addr;
      wdata_q <= dbus_data_wr;
      wmask_q <= dbus_wmask;
      rd_q    <= dbus_rd;
      wr_q    <= dbus_wr;
    end
  end

  // Byte-lane RAM write; a reset on the access edge suppresses it.
  always_ff @(posedge clk) begin
    if (!reset && access && acc_wr && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign dbus_data_ready = (state_q == StResp);
  assign dbus_error      = dbus_data_ready & err_q;
  assign dbus_data_rd    = rdata_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Self-checking bench for dbus_mem_responder (WAIT_STATES=2 main DUT, plus a
// WAIT_STATES=0 instance for back-to-back throughput).
module tb_dbus_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dbus_addr = '0, dbus_data_wr = '0;
  logic [3:0]  dbus_wmask = '0;
  logic        dbus_rd = 1'b0, dbus_wr = 1'b0;
  logic [31:0] dbus_data_rd;
  logic        dbus_data_ready, dbus_error;

  logic [31:0] a0 = '0, d0 = '0;
  logic [3:0]  m0 = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] rdata0;
  logic        rdy0, err0;

  always #5 clk = ~clk;

  dbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(WS), .BASE_ADDR(32'h0001_0000)) dut (
    .clk(clk), .reset(reset), .dbus_addr(dbus_addr), .dbus_data_wr(dbus_data_wr),
    .dbus_wmask(dbus_wmask), .dbus_rd(dbus_rd), .dbus_wr(dbus_wr),
    .dbus_data_rd(dbus_data_rd), .dbus_data_ready(dbus_data_ready), .dbus_error(dbus_error)
  );

  dbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .BASE_ADDR(32'h0001_0000)) dut0 (
    .clk(clk), .reset(reset), .dbus_addr(a0), .dbus_data_wr(d0),
    .dbus_wmask(m0), .dbus_rd(rd0), .dbus_wr(wr0),
    .dbus_data_rd(rdata0), .dbus_data_ready(rdy0), .dbus_error(err0)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        rd;
    logic        wr;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[18];
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the WAIT_STATES=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (dbus_data_ready) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_ready cyc=%0d got ready=1 want no response", cyc);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL ready_cycle got %0d want %0d", cyc, e.cyc);
        end
        n_cmp++;
        if (dbus_error !== e.err) begin
          n_fail++;
          $display("FAIL error_flag cyc=%0d got %0b want %0b", cyc, dbus_error, e.err);
        end
        n_cmp++;
        if (dbus_data_rd !== e.data) begin
          n_fail++;
          $display("FAIL data_rd cyc=%0d got %h want %h", cyc, dbus_data_rd, e.data);
        end
      end
    end else if (!reset) begin
      n_cmp++;
      if (dbus_error !== 1'b0) begin
        n_fail++;
        $display("FAIL error_without_ready cyc=%0d got %0b want 0", cyc, dbus_error);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Issue one request, hold it until ready, drop it the cycle after.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic r, input logic w, input logic err,
                         input logic [31:0] rdat, input bit toggle);
    exp_t e;
    int   start;
    int   bound;
    @(posedge clk); #1;
    dbus_addr = a; dbus_data_wr = d; dbus_wmask = m; dbus_rd = r; dbus_wr = w;
    e.cyc  = cyc + 1 + WS;
    e.err  = err;
    e.data = err ? 32'd0 : (r ? rdat : last_rd);
    last_rd = e.data;
    sb.push_back(e);
    start = resp_cnt;
    bound = 0;
    while (resp_cnt == start && bound < 30) begin
      @(posedge clk); #1;
      bound++;
      if (toggle) dbus_addr = dbus_addr + 32'h4;
    end
    if (resp_cnt == start) begin
      n_cmp++; n_fail++;
      $display("FAIL response_timeout addr=%h got no ready want ready", a);
      sb.delete();
    end
    dbus_rd = 1'b0; dbus_wr = 1'b0;
  endtask

  initial begin
    logic [4:0] pat;
    vecs[0]  = '{32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h0001_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0001_0004, 32'h0000_00AA, 4'h1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{32'h0001_0004, 32'h0,         4'hF, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEAA};
    vecs[4]  = '{32'h0001_0004, 32'h1234_0000, 4'hC, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{32'h0001_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_BEAA};
    vecs[6]  = '{32'h0001_0006, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{32'h0001_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_BEAA};
    vecs[8]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[9]  = '{32'h0001_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_BEAA};
    vecs[10] = '{32'h0001_1000, 32'h0,         4'h0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{32'h0001_0004, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0};
    vecs[12] = '{32'h0001_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_BEAA};
    vecs[13] = '{32'h0001_0004, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[14] = '{32'h0001_0004, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_BEAA};
    vecs[15] = '{32'h0001_0FFC, 32'h0BAD_CAFE, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{32'h0001_0FFC, 32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 32'h0BAD_CAFE};
    vecs[17] = '{32'h0001_0008, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, dbus_data_ready}, 32'd0);
    check("reset_error", {31'd0, dbus_error}, 32'd0);
    check("reset_data", dbus_data_rd, 32'd0);
    check("reset_ready_ws0", {31'd0, rdy0}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_req(vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].rd, vecs[i].wr,
              vecs[i].err, vecs[i].rdata, 1'b0);
    end

    // Address changes during WAIT must not affect the latched load.
    run_req(32'h0001_0004, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h1234_BEAA, 1'b1);

    // Reset on the edge entering RESP aborts the store and its response.
    @(posedge clk); #1;
    dbus_addr = 32'h0001_0008; dbus_data_wr = 32'h5555_5555; dbus_wmask = 4'hF; dbus_wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; dbus_wr = 1'b0;
    last_rd = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_ready_after_reset", {31'd0, dbus_data_ready}, 32'd0);
    end
    check("data_cleared_by_reset", dbus_data_rd, 32'd0);
    run_req(32'h0001_0008, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Zero-wait-state instance: preload two words.
    @(posedge clk); #1;
    a0 = 32'h0001_0000; d0 = 32'h1111_2222; m0 = 4'hF; wr0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr0 = 1'b0;
    @(posedge clk); #1;
    a0 = 32'h0001_0004; d0 = 32'h3333_4444; wr0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr0 = 1'b0;
    @(posedge clk);

    // Loads held continuously: ready expected in cycles 1 and 3 only.
    pat = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        a0 = 32'h0001_0000; rd0 = 1'b1;
      end
      if (i == 2) a0 = 32'h0001_0004;
      if (i == 4) rd0 = 1'b0;
      @(negedge clk);
      check($sformatf("ws0_ready_c%0d", i), {31'd0, rdy0}, {31'd0, pat[i]});
      if (i == 1) check("ws0_data_c1", rdata0, 32'h1111_2222);
      if (i == 3) check("ws0_data_c3", rdata0, 32'h3333_4444);
      if (pat[i]) check($sformatf("ws0_err_c%0d", i), {31'd0, err0}, 32'd0);
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL outstanding_responses got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
